pw_trigger_pulse_gen: RTL and testbench
=======================================

// Module: pw_trigger_pulse_gen
// PURPOSE
//  Sits directly downstream of the USB pattern matcher: consumes its one-cycle match
//  pulse and produces the PhyWhisperer external trigger output.
//  Each accepted match generates a programmable train of pulses:
//    delay -> pulse width -> gap -> ..., repeated up to a programmed count.
//  One-shot per arm; all timing counted in trigger_clk cycles.
// PARAMETERS
//  pDELAY_WIDTH = 20  width of delay register (cycles from match to first rising edge)
//  pWIDTH_WIDTH = 17  width of pulse-width and gap registers
//  pCOUNT_WIDTH = 8   width of pulse-count register
// PORTS
//  trigger_clk    in   1             sole clock; all ports synchronous to it
//  reset_i        in   1             synchronous, active-high reset
//  I_arm          in   1             arm level from register block (already synchronised)
//  I_match        in   1             one-cycle match pulse from pattern matcher
//  I_delay        in   pDELAY_WIDTH  cycles between match and first pulse rise
//  I_width        in   pWIDTH_WIDTH  high time per pulse (0 treated as 1)
//  I_gap          in   pWIDTH_WIDTH  low time between pulses (0 treated as 1)
//  I_num_pulses   in   pCOUNT_WIDTH  pulses per train (0 treated as 1)
//  O_trigger      out  1             registered trigger output
//  O_busy         out  1             high from match acceptance until train ends/aborts
//  O_done         out  1             one-cycle pulse when the last pulse of a train ends
//  O_pulse_count  out  pCOUNT_WIDTH  pulses completed in current/last train
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, armed flag 0; reset mid-train takes effect at the next edge.
//  Armed flag:
//   - set on a rising edge of I_arm (registered I_arm 0 -> 1);
//   - cleared when I_arm is low, on O_done, or on reset.
//   - Re-arming requires I_arm to go low and then high again.
//  Acceptance: I_match while armed and in IDLE.
//   - I_delay/I_width/I_gap/I_num_pulses are latched; O_pulse_count is cleared.
//   - Register changes mid-train have no effect on that train.
//  Matches while busy or disarmed are ignored (no queueing).
//  States:
//   - IDLE  -> DELAY on acceptance; goes straight to PULSE if latched delay == 0.
//   - DELAY -> PULSE after delay cycles.
//   - PULSE -> GAP when width expires and pulses remain; -> IDLE after the last pulse.
//   - GAP   -> PULSE after gap cycles.
//  Latency: match sampled at edge N; O_trigger first high after edge N+1+D (D = delay).
//   - D = 0 gives one cycle of latency.
//  O_trigger is high exactly W cycles per pulse and low exactly G cycles between pulses.
//  O_pulse_count increments on the cycle each pulse falls and holds after the train ends.
//  O_done:
//   - high on the single cycle following the last falling edge; O_busy is low that same cycle.
//   - armed flag cleared with it.
//  O_busy is high while in DELAY, PULSE or GAP.
//  Abort: I_arm low while busy -> next edge O_trigger=0, O_busy=0, state IDLE.
//   - Abort produces no O_done; O_pulse_count holds.
//  Simultaneous events:
//   - abort beats acceptance;
//   - a match on the O_done cycle is ignored (not armed).
//  Counters are down-counters loaded with value-1; no wrap is reachable.
//   - Maximum values (all ones) must be honoured exactly.
// TESTING
//  1. arm, match, D=0 W=1 G=1 P=1 -> O_trigger high only on cycle N+1; O_done at N+2; count=1.
//  2. D=10 W=3 G=2 P=3 -> rises at N+11, N+16, N+21, each 3 cycles high; O_done at N+24; count=3.
//  3. W=0 G=0 P=0 -> behaves as W=1 G=1 P=1; second match after done (no re-arm) -> no output.
//  4. Match during train (D=5 W=4 P=2), second match at N+7 -> ignored; identical waveform to single match.
//  5. I_arm dropped during 2nd pulse of P=4 -> O_trigger, O_busy low next edge; no O_done; count=1.
//  6. reset_i asserted mid-DELAY and mid-PULSE -> all outputs 0 next edge; new arm+match runs normally.

Source files
------------

// File: rtl/pw_trigger_pulse_gen_if.sv
// Match-in / trigger-out bundle between the controller side and the pulse generator.
interface pw_trigger_pulse_gen_if #(
  parameter int unsigned pDELAY_WIDTH = 20,
  parameter int unsigned pWIDTH_WIDTH = 17,
  parameter int unsigned pCOUNT_WIDTH = 8
);
  logic                    I_arm;
  logic                    I_match;
  logic [pDELAY_WIDTH-1:0] I_delay;
  logic [pWIDTH_WIDTH-1:0] I_width;
  logic [pWIDTH_WIDTH-1:0] I_gap;
  logic [pCOUNT_WIDTH-1:0] I_num_pulses;
  logic                    O_trigger;
  logic                    O_busy;
  logic                    O_done;
  logic [pCOUNT_WIDTH-1:0] O_pulse_count;

  modport master (
    output I_arm, I_match, I_delay, I_width, I_gap, I_num_pulses,
    input  O_trigger, O_busy, O_done, O_pulse_count
  );

  modport slave (
    input  I_arm, I_match, I_delay, I_width, I_gap, I_num_pulses,
    output O_trigger, O_busy, O_done, O_pulse_count
  );
endinterface

// File: rtl/pw_trigger_pulse_gen.sv
// Trigger pulse-train generator: one programmable delay/width/gap train per arm.
module pw_trigger_pulse_gen #(
  parameter int unsigned pDELAY_WIDTH = 20,
  parameter int unsigned pWIDTH_WIDTH = 17,
  parameter int unsigned pCOUNT_WIDTH = 8
) (
  input  logic                   trigger_clk,
  input  logic                   reset_i,
  pw_trigger_pulse_gen_if.slave  bus_io
);

  localparam int unsigned CntWidth =
      (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;
  localparam logic [CntWidth-1:0]     CntOne   = 1;
  localparam logic [pWIDTH_WIDTH-1:0] WOne     = 1;
  localparam logic [pCOUNT_WIDTH-1:0] CountOne = 1;

  typedef enum logic [1:0] {StIdle, StDelay, StPulse, StGap} state_e;

  state_e                  state_q, state_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [pWIDTH_WIDTH-1:0] width_q, width_d;  // latched width - 1
  logic [pWIDTH_WIDTH-1:0] gap_q, gap_d;      // latched gap - 1
  logic [pCOUNT_WIDTH-1:0] rem_q, rem_d;      // pulses remaining after the current one
  logic [pCOUNT_WIDTH-1:0] count_q, count_d;
  logic                    arm_q;
  logic                    armed_q, armed_d;
  logic                    trigger_q, trigger_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic                    abort;

  assign abort  = (state_q != StIdle) && !bus_io.I_arm;
  assign accept = bus_io.I_match && armed_q && bus_io.I_arm;

  // State, counters, latched config and registered outputs.
  always_ff @(posedge trigger_clk) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      arm_q     <= 1'b0;
      armed_q   <= 1'b0;
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      arm_q     <= bus_io.I_arm;
      armed_q   <= armed_d;
      trigger_q <= trigger_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state: phase sequencing, down-counter reloads, arm tracking and abort.
  // The delay phase also absorbs the fixed one-cycle acceptance latency, so it
  // lasts delay+1 cycles and a zero delay reaches PULSE after that single cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    gap_d   = gap_q;
    rem_d   = rem_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StDelay;
          cnt_d   = CntWidth'(bus_io.I_delay);
          width_d = (bus_io.I_width == '0) ? '0 : bus_io.I_width - WOne;
          gap_d   = (bus_io.I_gap == '0) ? '0 : bus_io.I_gap - WOne;
          rem_d   = (bus_io.I_num_pulses == '0) ? '0 : bus_io.I_num_pulses - CountOne;
          count_d = '0;
        end
      end
      StDelay: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = CntWidth'(width_q);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          count_d = count_q + CountOne;
          if (rem_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StGap;
            cnt_d   = CntWidth'(gap_q);
            rem_d   = rem_q - CountOne;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = CntWidth'(width_q);
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
      count_d = count_q;
    end
    armed_d = armed_q;
    if (!bus_io.I_arm || done_d) begin
      armed_d = 1'b0;
    end else if (!arm_q) begin
      armed_d = 1'b1;
    end
  end

  // Outputs are registered copies of the next-state decode.
  always_comb begin
    trigger_d = (state_d == StPulse);
    busy_d    = (state_d != StIdle);
  end

  assign bus_io.O_trigger     = trigger_q;
  assign bus_io.O_busy        = busy_q;
  assign bus_io.O_done        = done_q;
  assign bus_io.O_pulse_count = count_q;

endmodule

// File: tb/tb_pw_trigger_pulse_gen.sv
// Directed bench for pw_trigger_pulse_gen: table of trains plus corner sequences.
module tb_pw_trigger_pulse_gen;
  localparam int unsigned DW = 20;
  localparam int unsigned WW = 17;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pw_trigger_pulse_gen_if #(.pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW), .pCOUNT_WIDTH(CW)) bus ();

  pw_trigger_pulse_gen #(.pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW), .pCOUNT_WIDTH(CW)) dut (
    .trigger_clk(clk),
    .reset_i    (rst),
    .bus_io     (bus)
  );

  int checks = 0;
  int failures = 0;

  // d/w/g/p: programmed values; xm: cycle index of an extra match (0 = none);
  // done_k: hand-computed cycle of O_done after acceptance edge; cnt: final count.
  typedef struct {
    int d; int w; int g; int p; int xm; int done_k; int cnt;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Pulse i rises after edge 1+D+i*(W+G) and stays high W cycles.
  function automatic int exp_trig(input int k, input vec_t v);
    int w = eff(v.w);
    int g = eff(v.g);
    for (int i = 0; i < eff(v.p); i++) begin
      int s = 1 + v.d + i * (w + g);
      if (k >= s && k < s + w) return 1;
    end
    return 0;
  endfunction

  function automatic int exp_cnt(input int k, input vec_t v);
    int w = eff(v.w);
    int g = eff(v.g);
    int n = 0;
    for (int i = 0; i < eff(v.p); i++) begin
      if (1 + v.d + i * (w + g) + w <= k) n++;
    end
    return n;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    bus.I_arm = 1'b0;
    cycle();
    bus.I_arm = 1'b1;
    cycle();
  endtask

  task automatic set_cfg(input int d, input int w, input int g, input int p);
    bus.I_delay      = DW'(d);
    bus.I_width      = WW'(w);
    bus.I_gap        = WW'(g);
    bus.I_num_pulses = CW'(p);
  endtask

  task automatic check_idle(input string tag, input int cnt);
    chk({tag, "_trig"}, int'(bus.O_trigger), 0);
    chk({tag, "_busy"}, int'(bus.O_busy), 0);
    chk({tag, "_done"}, int'(bus.O_done), 0);
    chk({tag, "_cnt"}, int'(bus.O_pulse_count), cnt);
  endtask

  task automatic run_train(input vec_t v, input string tag);
    do_arm();
    set_cfg(v.d, v.w, v.g, v.p);
    bus.I_match = 1'b1;
    cycle();
    bus.I_match = 1'b0;
    // Config changes after acceptance must not disturb this train.
    set_cfg($urandom_range(0, 50), $urandom_range(0, 9), $urandom_range(0, 9),
            $urandom_range(0, 9));
    chk($sformatf("%s_busy_k0", tag), int'(bus.O_busy), 1);
    chk($sformatf("%s_trig_k0", tag), int'(bus.O_trigger), 0);
    chk($sformatf("%s_cnt_k0", tag), int'(bus.O_pulse_count), 0);
    for (int k = 1; k <= v.done_k + 3; k++) begin
      if (k == v.xm) bus.I_match = 1'b1;
      cycle();
      bus.I_match = 1'b0;
      chk($sformatf("%s_trig_k%0d", tag, k), int'(bus.O_trigger), exp_trig(k, v));
      chk($sformatf("%s_busy_k%0d", tag, k), int'(bus.O_busy), (k < v.done_k) ? 1 : 0);
      chk($sformatf("%s_done_k%0d", tag, k), int'(bus.O_done), (k == v.done_k) ? 1 : 0);
      chk($sformatf("%s_cnt_k%0d", tag, k), int'(bus.O_pulse_count),
          (k >= v.done_k) ? v.cnt : exp_cnt(k, v));
    end
  endtask

  initial begin
    vecs[0] = '{0, 1, 1, 1, 0, 2, 1};
    vecs[1] = '{10, 3, 2, 3, 0, 24, 3};
    vecs[2] = '{0, 0, 0, 0, 0, 2, 1};
    vecs[3] = '{5, 4, 2, 2, 7, 16, 2};
    vecs[4] = '{3, 2, 5, 2, 0, 13, 2};
    vecs[5] = '{0, 1, 1, 255, 0, 510, 255};
    vecs[6] = '{0, 1, 1, 1, 3, 2, 1};

    rst = 1'b1;
    bus.I_arm = 1'b0;
    bus.I_match = 1'b0;
    set_cfg(0, 0, 0, 0);
    cycle();
    cycle();
    check_idle("reset", 0);
    rst = 1'b0;
    cycle();

    foreach (vecs[i]) run_train(vecs[i], $sformatf("vec%0d", i));

    // Second match after done with I_arm still high: no re-arm, no output.
    run_train(vecs[2], "norearm_first");
    bus.I_match = 1'b1;
    cycle();
    bus.I_match = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_idle($sformatf("norearm_k%0d", k), 1);
      cycle();
    end

    // Abort during the 2nd pulse of a 4-pulse train.
    do_arm();
    set_cfg(0, 3, 2, 4);
    bus.I_match = 1'b1;
    cycle();
    bus.I_match = 1'b0;
    for (int k = 1; k <= 6; k++) cycle();
    chk("abort_pre_trig", int'(bus.O_trigger), 1);
    chk("abort_pre_cnt", int'(bus.O_pulse_count), 1);
    bus.I_arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_idle($sformatf("abort_k%0d", k), 1);
    end

    // Abort beats acceptance: match arriving with I_arm already low.
    do_arm();
    set_cfg(0, 1, 1, 1);
    bus.I_arm = 1'b0;
    bus.I_match = 1'b1;
    cycle();
    bus.I_match = 1'b0;
    check_idle("armlow_match0", 1);
    cycle();
    check_idle("armlow_match1", 1);

    // Reset mid-DELAY, then a normal train.
    do_arm();
    set_cfg(5, 2, 1, 1);
    bus.I_match = 1'b1;
    cycle();
    bus.I_match = 1'b0;
    cycle();
    cycle();
    chk("rstdly_pre_busy", int'(bus.O_busy), 1);
    rst = 1'b1;
    cycle();
    check_idle("rstdly", 0);
    rst = 1'b0;
    run_train(vecs[1], "post_rstdly");

    // Reset mid-PULSE, then a normal train.
    do_arm();
    set_cfg(0, 5, 1, 2);
    bus.I_match = 1'b1;
    cycle();
    bus.I_match = 1'b0;
    cycle();
    cycle();
    chk("rstpls_pre_trig", int'(bus.O_trigger), 1);
    rst = 1'b1;
    cycle();
    check_idle("rstpls", 0);
    rst = 1'b0;
    run_train(vecs[4], "post_rstpls");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
